// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared state and grant encodings for the RAM port arbiter
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_t;

    function automatic grant_t other_grant(input grant_t g);
        return (g == GNT_A) ? GNT_B : GNT_A;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rtl/ram_port_arbiter_rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
    import ram_port_arbiter_pkg::*;
(
    input  logic   req_a,
    input  logic   req_b,
    input  grant_t last_grant,
    output logic   gnt_valid,
    output grant_t gnt
);

    always_comb begin
        gnt_valid = req_a | req_b;
        if (req_a && req_b) begin
            gnt = other_grant(last_grant);
        end else if (req_b) begin
            gnt = GNT_B;
        end else begin
            gnt = GNT_A;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one asynchronous RAM port between requesters A and B
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADLINES   = 8,
    parameter int DATALINES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_a,
    input  logic                 we_a,
    input  logic [ADLINES-1:0]   addr_a,
    input  logic [DATALINES-1:0] wdata_a,
    output logic [DATALINES-1:0] rdata_a,
    output logic                 done_a,
    input  logic                 req_b,
    input  logic                 we_b,
    input  logic [ADLINES-1:0]   addr_b,
    input  logic [DATALINES-1:0] wdata_b,
    output logic [DATALINES-1:0] rdata_b,
    output logic                 done_b,
    output logic [ADLINES-1:0]   ram_address,
    output logic [DATALINES-1:0] ram_datain,
    input  logic [DATALINES-1:0] ram_dataout,
    output logic                 ram_read,
    output logic                 ram_write
);

    state_t                 state_q, state_d;
    grant_t                 grant_q, grant_d;
    grant_t                 last_grant_q, last_grant_d;
    logic                   we_q, we_d;
    logic [ADLINES-1:0]     ram_address_q, ram_address_d;
    logic [DATALINES-1:0]   ram_datain_q, ram_datain_d;
    logic                   ram_read_q, ram_read_d;
    logic                   ram_write_q, ram_write_d;
    logic                   done_a_q, done_a_d;
    logic                   done_b_q, done_b_d;
    logic [DATALINES-1:0]   rdata_a_q, rdata_a_d;
    logic [DATALINES-1:0]   rdata_b_q, rdata_b_d;
    logic                   gnt_valid;
    grant_t                 gnt;

    rr_arb2 u_rr_arb2 (
        .req_a      (req_a),
        .req_b      (req_b),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt        (gnt)
    );

    // Strobes and done pulses default low so each is a single-cycle registered pulse.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        we_d          = we_q;
        ram_address_d = ram_address_q;
        ram_datain_d  = ram_datain_q;
        ram_read_d    = 1'b0;
        ram_write_d   = 1'b0;
        done_a_d      = 1'b0;
        done_b_d      = 1'b0;
        rdata_a_d     = rdata_a_q;
        rdata_b_d     = rdata_b_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    grant_d       = gnt;
                    last_grant_d  = gnt;
                    we_d          = (gnt == GNT_B) ? we_b    : we_a;
                    ram_address_d = (gnt == GNT_B) ? addr_b  : addr_a;
                    ram_datain_d  = (gnt == GNT_B) ? wdata_b : wdata_a;
                    state_d       = ST_SETUP;
                end
            end
            ST_SETUP: begin
                ram_read_d  = ~we_q;
                ram_write_d = we_q;
                state_d     = ST_STROBE;
            end
            ST_STROBE: begin
                if (!we_q) begin
                    if (grant_q == GNT_A) rdata_a_d = ram_dataout;
                    else                  rdata_b_d = ram_dataout;
                end
                done_a_d = (grant_q == GNT_A);
                done_b_d = (grant_q == GNT_B);
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= GNT_A;
            last_grant_q  <= GNT_B;
            we_q          <= 1'b0;
            ram_address_q <= '0;
            ram_datain_q  <= '0;
            ram_read_q    <= 1'b0;
            ram_write_q   <= 1'b0;
            done_a_q      <= 1'b0;
            done_b_q      <= 1'b0;
            rdata_a_q     <= '0;
            rdata_b_q     <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            we_q          <= we_d;
            ram_address_q <= ram_address_d;
            ram_datain_q  <= ram_datain_d;
            ram_read_q    <= ram_read_d;
            ram_write_q   <= ram_write_d;
            done_a_q      <= done_a_d;
            done_b_q      <= done_b_d;
            rdata_a_q     <= rdata_a_d;
            rdata_b_q     <= rdata_b_d;
        end
    end

    assign ram_address = ram_address_q;
    assign ram_datain  = ram_datain_q;
    assign ram_read    = ram_read_q;
    assign ram_write   = ram_write_q;
    assign done_a      = done_a_q;
    assign done_b      = done_b_q;
    assign rdata_a     = rdata_a_q;
    assign rdata_b     = rdata_b_q;

endmodule
